mul_pipe: RTL and testbench
===========================

# mul_pipe

Parametrised, fully pipelined integer multiply(-accumulate) unit for the execute stage, successor to the fixed 3-cycle 33×33 multiplier wrapper. Accepts one operation per cycle through a valid/ready handshake. Supports signed and unsigned operands, optional add/subtract of a caller-supplied 2·WIDTH accumulator (MADD/MSUB-style HI/LO update), and a tag that travels with each operation. Provides back-pressure stall, flush-on-cancel and a busy indication for the hazard unit.

## Interface
- WIDTH, 32, operand width in bits (≥ 8)
- STAGES, 3, latency in cycles from acceptance to out_valid (≥ 1)
- TAG_W, 5, width of the pass-through tag (≥ 1)

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all valid state
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept this cycle
- in_signed  in  1  1: operands are two's complement; 0: unsigned
- in_acc  in  2  00 product only, 01 acc + product, 10 acc − product, 11 reserved (treated as 00)
- in_a, in_b  in  WIDTH  operands
- in_acc_val  in  2·WIDTH  accumulator value {HI,LO}, sampled at acceptance
- in_tag  in  TAG_W  opaque tag
- cancel  in  1  flush all in-flight operations
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_hi, out_lo  out  WIDTH  result upper/lower halves
- out_tag  out  TAG_W  tag of result
- busy  out  1  any stage holds a valid operation

## Operation
- Acceptance: in_valid && in_ready && !cancel at a rising edge.
- Operands extended to WIDTH+1 bits (sign-extend if in_signed, else zero-extend); product is the low 2·WIDTH bits of the (WIDTH+1)×(WIDTH+1) product.
- Accumulate applied after the product, modulo 2^(2·WIDTH); no saturation, no overflow flag.
- Pipeline: STAGES register stages, each with a valid bit carrying result/partials, in_acc, in_acc_val and tag. Product computation may be distributed across stages in any way; the last stage is the output register.
- stall = out_valid && !out_ready. When stall, every stage holds; otherwise every stage advances (bubbles propagate, no compaction required).
- in_ready = !stall (combinational).
- out_valid = valid bit of last stage; out_hi/out_lo/out_tag are don't-care when out_valid = 0.
- busy = OR of all stage valid bits.
- cancel: at the edge, all valid bits clear, including the operation being presented that cycle (not accepted). cancel overrides stall. Data registers need not clear.
- reset: asynchronous; all valid bits to 0 immediately. Reset outputs: out_valid 0, busy 0, in_ready 1 (once reset deasserts, as stall is 0); out_hi/out_lo/out_tag 0.
- Reset or cancel mid-operation: in-flight results are lost, never emitted.

## Timing
- Latency: operation accepted at edge N appears with out_valid = 1 after edge N+STAGES−1 (STAGES=1: visible right after the accepting edge), absent stalls.
- Throughput: 1 operation/cycle; results emerge in acceptance order.
- Each stall cycle adds exactly one cycle to latency of every in-flight operation.
- Result handed off at edge where out_valid && out_ready; a new result may appear same edge.
- Simultaneous cancel and out_ready: the current output is not considered delivered; it is flushed.
- No combinational path from in_* operands to out_*; only out_ready → in_ready is combinational.

## Test plan
- WIDTH=32, STAGES=3, signed, in_a=0xFFFFFFFF, in_b=2, in_acc=00, tag 7 -> out_valid 3 cycles after acceptance, {hi,lo}=0xFFFFFFFF_FFFFFFFE, out_tag 7.
- Unsigned, in_a=0xFFFFFFFF, in_b=2 -> 0x00000001_FFFFFFFE; signed 0x80000000×0x80000000 -> 0x40000000_00000000.
- Accumulate: in_acc=01, acc=5, 3×4 -> 0x11; in_acc=10, acc=0, 1×1 -> 0xFFFFFFFF_FFFFFFFF (wrap).
- Back-to-back 5 ops, out_ready held 1 -> 5 consecutive out_valid cycles, tags 0..4 in order; then out_ready=0 for 2 cycles -> in_ready 0, outputs hold, no op lost or duplicated.
- cancel asserted with 3 ops in flight plus one presented -> busy 0 and out_valid 0 next cycle; no tagged result from those ops ever appears.
- reset asserted mid-pipeline, asynchronously between edges -> out_valid/busy drop immediately; after release in_ready 1 and first new op completes in 3 cycles.

Source files
------------

// File: rtl/mul_pipe_if.sv
// ---------------------------------------------------------------------------
// mul_pipe_if
// Bundles the operation/result handshake of the pipelined multiply(-accumulate)
// unit so the execute stage and the unit share one connection point.
//
// Signals (direction seen from the unit, i.e. the slave modport):
//   in_valid    in   operation presented
//   in_ready    out  unit can accept an operation this cycle
//   in_signed   in   1: operands are two's complement, 0: unsigned
//   in_acc      in   00 product, 01 acc + product, 10 acc - product, 11 as 00
//   in_a, in_b  in   WIDTH-bit operands
//   in_acc_val  in   2*WIDTH accumulator {HI,LO}
//   in_tag      in   opaque tag carried alongside the operation
//   cancel      in   flush every in-flight operation
//   out_valid   out  result available
//   out_ready   in   consumer takes the result
//   out_hi/lo   out  upper/lower halves of the result
//   out_tag     out  tag of the result
//   busy        out  any pipeline stage holds a valid operation
// ---------------------------------------------------------------------------
interface mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [1:0]         in_acc;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [2*WIDTH-1:0] in_acc_val;
  logic [TAG_W-1:0]   in_tag;
  logic               cancel;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_hi;
  logic [WIDTH-1:0]   out_lo;
  logic [TAG_W-1:0]   out_tag;
  logic               busy;

  // Requester side (execute stage / hazard unit)
  modport master (
    output in_valid, in_signed, in_acc, in_a, in_b, in_acc_val, in_tag,
    output cancel, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, out_tag, busy
  );

  // Multiplier side
  modport slave (
    input  in_valid, in_signed, in_acc, in_a, in_b, in_acc_val, in_tag,
    input  cancel, out_ready,
    output in_ready, out_valid, out_hi, out_lo, out_tag, busy
  );
endinterface

// File: rtl/mul_pipe.sv
// ---------------------------------------------------------------------------
// mul_pipe
// Fully pipelined integer multiply(-accumulate) unit. One operation per cycle
// enters through a valid/ready handshake and emerges STAGES cycles later in
// acceptance order, together with its tag.
//
// Ports:
//   clk    in  clock, all state updates on the rising edge
//   reset  in  asynchronous, active-high; clears every valid bit and datapath
//   bus    mul_pipe_if.slave  operation inputs, result outputs, cancel,
//          back-pressure and busy (see mul_pipe_if for the signal list)
//
// Work split across the pipeline:
//   STAGES = 1 : extend, multiply and accumulate all before the only register
//   STAGES = 2 : stage 0 captures extended operands, stage 1 multiplies and
//                accumulates
//   STAGES >= 3: stage 0 captures operands, stage 1 multiplies, stage 2
//                accumulates, remaining stages just carry the result
// The last stage is always the output register, so nothing on in_* reaches
// out_* without passing a flop.
// ---------------------------------------------------------------------------
module mul_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic     clk,
  input  logic     reset,
  mul_pipe_if.slave bus
);

  localparam int LAST    = STAGES - 1;
  localparam int PROD_ST = (STAGES >= 2) ? 1 : 0;
  localparam int ACC_ST  = (STAGES >= 3) ? 2 : PROD_ST;

  // Everything an operation carries while it travels down the pipe. The
  // operands are kept WIDTH+1 wide so signed and unsigned share one multiplier.
  typedef struct packed {
    logic [WIDTH:0]     a;
    logic [WIDTH:0]     b;
    logic [2*WIDTH-1:0] res;
    logic [1:0]         acc_mode;
    logic [2*WIDTH-1:0] acc_val;
    logic [TAG_W-1:0]   tag;
  } stage_t;

  stage_t             data_q [STAGES];
  stage_t             data_d [STAGES];
  stage_t             work   [STAGES];
  stage_t             in_rec;
  logic [STAGES-1:0]  valid_q;
  logic [STAGES-1:0]  valid_d;
  logic               stall;

  // Processing done while a record moves into stage idx. Only the low 2*WIDTH
  // bits of the (WIDTH+1)x(WIDTH+1) product are kept, and those depend only
  // on the low 2*WIDTH bits of each sign-extended operand, so a 2*WIDTH-wide
  // multiply is exact. The reserved accumulate code falls into the default.
  function automatic stage_t stage_work(input stage_t rec, input int idx);
    stage_t             r;
    logic [2*WIDTH-1:0] ea;
    logic [2*WIDTH-1:0] eb;
    r  = rec;
    ea = {{(WIDTH-1){rec.a[WIDTH]}}, rec.a};
    eb = {{(WIDTH-1){rec.b[WIDTH]}}, rec.b};
    if (idx == PROD_ST) begin
      r.res = ea * eb;
    end
    if (idx == ACC_ST) begin
      case (r.acc_mode)
        2'b01:   r.res = r.acc_val + r.res;
        2'b10:   r.res = r.acc_val - r.res;
        default: r.res = r.res;
      endcase
    end
    return r;
  endfunction

  // Back-pressure: a result waiting at the output that nobody takes freezes
  // the whole pipe, and the same condition blocks new operations.
  always_comb begin
    stall = valid_q[LAST] & ~bus.out_ready;
  end

  // Build the incoming record (operand extension by in_signed) and compute
  // what each stage would hold if the pipe advanced this cycle.
  always_comb begin
    in_rec          = '0;
    in_rec.a        = {bus.in_signed & bus.in_a[WIDTH-1], bus.in_a};
    in_rec.b        = {bus.in_signed & bus.in_b[WIDTH-1], bus.in_b};
    in_rec.acc_mode = bus.in_acc;
    in_rec.acc_val  = bus.in_acc_val;
    in_rec.tag      = bus.in_tag;
    work[0] = stage_work(in_rec, 0);
    for (int i = 1; i < STAGES; i++) begin
      work[i] = stage_work(data_q[i-1], i);
    end
  end

  // Next state: cancel wipes every valid bit (including the operation being
  // presented) and wins over stall; stall holds everything; otherwise every
  // stage advances, bubbles included. Data registers are not cleared by
  // cancel since the valid bits already hide them.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < STAGES; i++) begin
      data_d[i] = stall ? data_q[i] : work[i];
    end
    if (bus.cancel) begin
      valid_d = '0;
    end else if (!stall) begin
      valid_d[0] = bus.in_valid;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  // Pipeline registers; reset clears the datapath too so the result outputs
  // read zero while reset is applied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = valid_q[LAST];
  assign bus.out_hi    = data_q[LAST].res[2*WIDTH-1:WIDTH];
  assign bus.out_lo    = data_q[LAST].res[WIDTH-1:0];
  assign bus.out_tag   = data_q[LAST].tag;
  assign bus.busy      = |valid_q;

endmodule

// File: tb/tb_mul_pipe.sv
// ---------------------------------------------------------------------------
// tb_mul_pipe
// Scoreboard bench for mul_pipe (WIDTH=32, STAGES=3, TAG_W=5). Every accepted
// operation pushes its expected result, tag and acceptance cycle; the monitor
// on the falling edge predicts out_valid/busy/in_ready from the queue and
// pops/compares on each handoff.
// ---------------------------------------------------------------------------
module tb_mul_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 3;
  localparam int TAG_W  = 5;

  typedef struct {
    logic [63:0]      res;
    logic [TAG_W-1:0] tag;
    int               cyc;
    int               stalls;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  exp_t        sb[$];
  exp_t        mon_e;
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  int          stall_cnt    = 0;
  bit          acc_flag     = 1'b0;
  bit          rand_done    = 1'b0;
  logic [63:0] drv_exp      = '0;
  logic        mon_ov;
  logic        mon_ir;

  mul_pipe_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

  mul_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock and a cycle counter used for latency bookkeeping
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, obs, exp, $time);
    end
  endtask

  // Reference result: extend to 128 bits, multiply, keep 64, then accumulate
  function automatic logic [63:0] modelResult(input logic s, input logic [1:0] acc,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [63:0] av);
    logic [127:0] ea;
    logic [127:0] eb;
    logic [127:0] p;
    ea = s ? {{96{a[31]}}, a} : {96'b0, a};
    eb = s ? {{96{b[31]}}, b} : {96'b0, b};
    p  = ea * eb;
    case (acc)
      2'b01:   return av + p[63:0];
      2'b10:   return av - p[63:0];
      default: return p[63:0];
    endcase
  endfunction

  // Monitor: predicts handshake outputs from the scoreboard, checks results
  // on handoff, records acceptances.
  always @(negedge clk) begin
    if (!reset) begin
      mon_ov = 1'b0;
      if (sb.size() > 0) begin
        mon_ov = ((cyc - sb[0].cyc) - (stall_cnt - sb[0].stalls)) >= STAGES;
      end
      mon_ir = !(mon_ov && !bus.out_ready);
      checkOutput("out_valid", 64'(bus.out_valid), 64'(mon_ov));
      checkOutput("busy", 64'(bus.busy), 64'(sb.size() > 0));
      checkOutput("in_ready", 64'(bus.in_ready), 64'(mon_ir));
      if (bus.cancel) begin
        sb.delete();
      end else begin
        if (mon_ov && bus.out_ready) begin
          checkOutput("result", {bus.out_hi, bus.out_lo}, sb[0].res);
          checkOutput("out_tag", 64'(bus.out_tag), 64'(sb[0].tag));
          void'(sb.pop_front());
        end
        if (mon_ov && !bus.out_ready) stall_cnt++;
        if (bus.in_valid && mon_ir) begin
          mon_e.res    = drv_exp;
          mon_e.tag    = bus.in_tag;
          mon_e.cyc    = cyc;
          mon_e.stalls = stall_cnt;
          sb.push_back(mon_e);
          acc_flag = 1'b1;
        end
      end
    end
  end

  // Present one operation (called at posedge+1) and hold it until accepted
  task automatic applyStimulus(input logic s, input logic [1:0] acc,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [63:0] av, input logic [TAG_W-1:0] tag,
                               input logic [63:0] expv);
    bus.in_signed  = s;
    bus.in_acc     = acc;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_acc_val = av;
    bus.in_tag     = tag;
    drv_exp        = expv;
    acc_flag       = 1'b0;
    bus.in_valid   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      if (acc_flag) break;
    end
    if (!acc_flag) checkOutput("accept_timeout", 64'(acc_flag), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic applyRandom(input logic [TAG_W-1:0] tag);
    logic        s;
    logic [1:0]  acc;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] av;
    s   = 1'($urandom_range(0, 1));
    acc = 2'($urandom_range(0, 3));
    a   = $urandom;
    b   = $urandom;
    av  = {$urandom, $urandom};
    applyStimulus(s, acc, a, b, av, tag, modelResult(s, acc, a, b, av));
  endtask

  // Wait (bounded) until every accepted operation has been delivered
  task automatic waitDrain();
    for (int k = 0; k < 200; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checkOutput("drain", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_signed  = 1'b0;
    bus.in_acc     = 2'b00;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_acc_val = '0;
    bus.in_tag     = '0;
    bus.cancel     = 1'b0;
    bus.out_ready  = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    checkOutput("reset_out_hi", 64'(bus.out_hi), 64'd0);
    checkOutput("reset_out_lo", 64'(bus.out_lo), 64'd0);
    checkOutput("reset_out_tag", 64'(bus.out_tag), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed values with fixed expected results
    applyStimulus(1'b1, 2'b00, 32'hFFFFFFFF, 32'd2, 64'd0, 5'd7, 64'hFFFFFFFF_FFFFFFFE);
    waitDrain();
    applyStimulus(1'b0, 2'b00, 32'hFFFFFFFF, 32'd2, 64'd0, 5'd1, 64'h00000001_FFFFFFFE);
    waitDrain();
    applyStimulus(1'b1, 2'b00, 32'h80000000, 32'h80000000, 64'd0, 5'd2, 64'h40000000_00000000);
    waitDrain();
    applyStimulus(1'b0, 2'b01, 32'd3, 32'd4, 64'd5, 5'd3, 64'h11);
    waitDrain();
    applyStimulus(1'b0, 2'b10, 32'd1, 32'd1, 64'd0, 5'd4, 64'hFFFFFFFF_FFFFFFFF);
    waitDrain();
    applyStimulus(1'b1, 2'b11, 32'd3, 32'd4, 64'h1234, 5'd5, 64'd12);
    waitDrain();
    applyStimulus(1'b1, 2'b01, 32'hFFFFFFFF, 32'd3, 64'd10, 5'd6, 64'd7);
    waitDrain();

    // Back-to-back, consumer always ready
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'b00, 32'(i + 1), 32'(i + 100), 64'd0, 5'(i),
                    modelResult(1'b0, 2'b00, 32'(i + 1), 32'(i + 100), 64'd0));
    end
    waitDrain();

    // Back-to-back with a two-cycle consumer stall in the middle
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          applyStimulus(1'b1, 2'b00, 32'(i * 7 + 3), 32'hFFFFFFF0, 64'd0, 5'(i + 8),
                        modelResult(1'b1, 2'b00, 32'(i * 7 + 3), 32'hFFFFFFF0, 64'd0));
        end
      end
      begin
        repeat (4) begin @(posedge clk); #1; end
        bus.out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
      end
    join
    waitDrain();

    // Random operations with random gaps and random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
          applyRandom(5'(i));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    waitDrain();

    // Cancel with three operations in flight (one at the output) plus one presented
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b00, 32'd9, 32'd9, 64'd0, 5'(20 + i), 64'd81);
    end
    bus.in_tag   = 5'd23;
    bus.in_valid = 1'b1;
    bus.cancel   = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel   = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("cancel_busy", 64'(bus.busy), 64'd0);
    checkOutput("cancel_out_valid", 64'(bus.out_valid), 64'd0);
    repeat (6) begin @(posedge clk); #1; end

    // Asynchronous reset between edges with two operations in flight
    applyStimulus(1'b0, 2'b00, 32'd2, 32'd2, 64'd0, 5'd10, 64'd4);
    applyStimulus(1'b0, 2'b00, 32'd3, 32'd3, 64'd0, 5'd11, 64'd9);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("async_reset_busy", 64'(bus.busy), 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b10, 32'd6, 32'hFFFFFFFF, 64'd100, 5'd12, 64'd106);
    waitDrain();
    repeat (3) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
